mult8x8_arbiter: RTL

Round-robin arbiter and sequencer that shares one external mult8x8 sequential multiplier between NREQ requesters. It accepts operand pairs through a req/grant handshake and drives the multiplier's start strobe and operands. It waits for the multiplier's done flag and then returns the 16-bit product to the owning requester. It guarantees that start is never re-asserted while an operation is in flight, because a restart clears the multiplier's product.

---
 rtl/mult_arb_pkg.sv | 16 +
 rtl/mult8x8_arbiter_rr_pick.sv | 46 ++++
 rtl/mult8x8_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the mult8x8 round-robin arbiter/sequencer.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int OPW         = 8;
    localparam int PRODW       = 16;
    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 32;

endpackage

// File: rtl/mult8x8_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_pick
    import mult_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_win_oh,
    output logic [IW-1:0]   o_win_idx,
    output logic            o_any
);

    localparam int SW = IW + 1;
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    logic [SW-1:0] w_slot;

    // Scan offsets from the far end down so the nearest requester to the pointer wins last.
    always_comb begin
        o_win_idx = '0;
        o_any     = 1'b0;
        w_slot    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_slot = {1'b0, i_ptr} + SW'(k);
            if (w_slot >= SW'(NREQ)) begin
                w_slot = w_slot - SW'(NREQ);
            end else begin
                w_slot = w_slot;
            end
            if (i_req[w_slot[IW-1:0]]) begin
                o_win_idx = w_slot[IW-1:0];
                o_any     = 1'b1;
            end else begin
                o_win_idx = o_win_idx;
            end
        end
        if (o_any) begin
            o_win_oh = ONE << o_win_idx;
        end else begin
            o_win_oh = '0;
        end
    end

endmodule

// File: rtl/mult8x8_arbiter.sv
// Shares one external mult8x8 sequential multiplier between NREQ requesters.
// Optional done-flag watchdog enabled by defining MULT_TIMEOUT_EN.
module mult8x8_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ           = NREQ_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset_a,
    input  logic [NREQ-1:0]     req,
    input  logic [OPW*NREQ-1:0] a_in,
    input  logic [OPW*NREQ-1:0] b_in,
    output logic [NREQ-1:0]     grant,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [PRODW-1:0]    rsp_prod,
    output logic                rsp_err,
    output logic                busy,
    output logic [OPW-1:0]      mult_dataa,
    output logic [OPW-1:0]      mult_datab,
    output logic                mult_start,
    input  logic [PRODW-1:0]    mult_product,
    input  logic                mult_done
);

    localparam int IW = $clog2(NREQ);

    state_t            r_state;
    state_t            w_next;
    logic [IW-1:0]     r_ptr;
    logic [NREQ-1:0]   r_owner_oh;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   r_rsp_valid;
    logic [PRODW-1:0]  r_rsp_prod;
    logic              r_rsp_err;
    logic              r_busy;
    logic [OPW-1:0]    r_dataa;
    logic [OPW-1:0]    r_datab;
    logic              r_start;
    logic              r_done_q;
    logic [NREQ-1:0]   w_win_oh;
    logic [IW-1:0]     w_win_idx;
    logic              w_any;
    logic              w_done_edge;
    logic              w_timeout;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .o_win_oh  (w_win_oh),
        .o_win_idx (w_win_idx),
        .o_any     (w_any)
    );

    // A done level left over from the previous operation must not count as completion.
    assign w_done_edge = mult_done & ~r_done_q;

`ifdef MULT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;

    // Watchdog: cleared in START, counts WAIT cycles.
    always_ff @(posedge clk) begin
        if (reset_a) begin
            r_cnt <= '0;
        end else if (r_state == START) begin
            r_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign w_timeout = (r_state == WAIT) && (r_cnt == CW'(TIMEOUT_CYCLES - 1)) && !w_done_edge;
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next = START;
                end else begin
                    w_next = IDLE;
                end
            end
            START: w_next = WAIT;
            WAIT: begin
                if (w_done_edge || w_timeout) begin
                    w_next = RESP;
                end else begin
                    w_next = WAIT;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, pointer and registered outputs; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (reset_a) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_owner_oh  <= '0;
            r_grant     <= '0;
            r_rsp_valid <= '0;
            r_rsp_prod  <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_dataa     <= '0;
            r_datab     <= '0;
            r_start     <= 1'b0;
            r_done_q    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_done_q    <= mult_done;
            r_busy      <= (w_next != IDLE);
            r_grant     <= '0;
            r_start     <= 1'b0;
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_dataa    <= a_in[w_win_idx*OPW +: OPW];
                        r_datab    <= b_in[w_win_idx*OPW +: OPW];
                        r_owner_oh <= w_win_oh;
                        r_grant    <= w_win_oh;
                        r_start    <= 1'b1;
                        r_ptr      <= (w_win_idx == IW'(NREQ - 1)) ? '0 : w_win_idx + IW'(1);
                    end
                end
                WAIT: begin
                    if (w_done_edge) begin
                        r_rsp_prod  <= mult_product;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= r_owner_oh;
                    end else if (w_timeout) begin
                        r_rsp_prod  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= r_owner_oh;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_prod   = r_rsp_prod;
    assign rsp_err    = r_rsp_err;
    assign busy       = r_busy;
    assign mult_dataa = r_dataa;
    assign mult_datab = r_datab;
    assign mult_start = r_start;

endmodule
